// File: rtl/display_cmd_pkg.sv
// Shared definitions for the UART-driven 7-segment display controller.
// Contents: FSM state type, ASCII protocol characters, blank digit code and
// the digit-code to ASCII helper used for read-back replies.
package display_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CAP_B0   = 3'd1,
    ST_WAIT_B1  = 3'd2,
    ST_CAP_B1   = 3'd3,
    ST_CHECK    = 3'd4,
    ST_EXEC     = 3'd5,
    ST_READBACK = 3'd6,
    ST_REPLY    = 3'd7
  } state_t;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam logic [7:0] ASCII_NINE   = 8'h39;
  localparam logic [7:0] ASCII_SPACE  = 8'h20;
  localparam logic [7:0] CMD_CLEAR_B0 = 8'h43;  // 'C'
  localparam logic [7:0] CMD_CLEAR_B1 = 8'h21;  // '!'
  localparam logic [7:0] CMD_READ_B0  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_READ_B1  = 8'h3F;  // '?'
  localparam logic [7:0] OK_B0        = 8'h4F;  // 'O'
  localparam logic [7:0] OK_B1        = 8'h6B;  // 'k'
  localparam logic [7:0] ER_B0        = 8'h45;  // 'E'
  localparam logic [7:0] ER_B1        = 8'h72;  // 'r'
  localparam logic [3:0] BLANK_CODE   = 4'hF;

  // A blank digit reads back as a space, anything else as its ASCII numeral.
  function automatic logic [7:0] code_to_ascii(input logic [3:0] code);
    logic [7:0] ch;
    if (code == BLANK_CODE) begin
      ch = ASCII_SPACE;
    end else begin
      ch = ASCII_ZERO + {4'h0, code};
    end
    return ch;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Multiplexed display scanner: steps through the digits one slot at a time.
// Ports:
//   clock, reset  system clock, synchronous active-high reset
//   numbers       packed digit codes, digit i at [4i+3:4i]
//   dig           one-hot digit enable, digit 0 after reset
//   dig_value     code of the enabled digit, registered alongside dig
module seg_scan
  import display_cmd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 5000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] numbers,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [3:0]              dig_value
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      scan_cnt_r;
  logic [IDX_W-1:0]      idx_r;
  logic [NUM_DIGITS-1:0] dig_r;
  logic [3:0]            dig_value_r;
  logic                  slot_end_s;
  logic [IDX_W-1:0]      idx_next_s;

  // Next digit index: advance at the end of each slot, wrapping at the top digit.
  always_comb begin
    slot_end_s = (scan_cnt_r == CNT_LAST);
    idx_next_s = idx_r;
    if (slot_end_s) begin
      if (idx_r == IDX_LAST) begin
        idx_next_s = '0;
      end else begin
        idx_next_s = idx_r + 1'b1;
      end
    end else begin
      idx_next_s = idx_r;
    end
  end

  // Slot counter, one-hot enable and value register; dig_value follows the
  // next index so it is always aligned with dig.
  always_ff @(posedge clock) begin
    if (reset) begin
      scan_cnt_r  <= '0;
      idx_r       <= '0;
      dig_r       <= NUM_DIGITS'(1'b1);
      dig_value_r <= BLANK_CODE;
    end else begin
      if (slot_end_s) begin
        scan_cnt_r <= '0;
      end else begin
        scan_cnt_r <= scan_cnt_r + 1'b1;
      end
      idx_r       <= idx_next_s;
      dig_r       <= NUM_DIGITS'(1'b1) << idx_next_s;
      dig_value_r <= numbers[{idx_next_s, 2'b00} +: 4];
    end
  end

  assign dig       = dig_r;
  assign dig_value = dig_value_r;

endmodule

// File: rtl/display_cmd_ctrl.sv
// UART command controller for an N-digit multiplexed 7-segment display.
// Pops 2-byte ASCII frames from the RX FIFO, executes digit set / clear-all /
// read-back commands and pushes "Ok", "Er" or read-back text to the TX FIFO.
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   uart_rx_fifo_*       RX FIFO pop interface (data valid the cycle after read)
//   uart_tx_fifo_*       TX FIFO push interface with full backpressure
//   dig, dig_value       scan outputs (one-hot enable, code of enabled digit)
//   display_numbers      all digit codes, digit i at [4i+3:4i], 4'hF = blank
//   frame_error          one-cycle pulse when an "Er" reply starts
module display_cmd_ctrl
  import display_cmd_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              uart_rx_fifo_data,
  output logic                    uart_rx_fifo_read,
  input  logic                    uart_rx_fifo_empty,
  output logic [7:0]              uart_tx_fifo_data,
  output logic                    uart_tx_fifo_write,
  input  logic                    uart_tx_fifo_full,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic [3:0]              dig_value,
  output logic [4*NUM_DIGITS-1:0] display_numbers,
  output logic                    frame_error
);

  localparam int CNT_W = $clog2(NUM_DIGITS + 3);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RB_LAST = CNT_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                  state_r;
  logic [7:0]              b0_r;
  logic [7:0]              b1_r;
  logic [4*NUM_DIGITS-1:0] disp_r;
  logic [4*NUM_DIGITS-1:0] snap_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [TMO_W-1:0]        tmo_cnt_r;
  logic                    reply_ok_r;
  logic                    frame_error_r;

  logic [7:0] digit_off_s;
  logic       digit_cmd_s;
  logic       b1_num_s;
  logic       b1_space_s;
  logic       clear_cmd_s;
  logic       read_cmd_s;
  logic       valid_s;
  logic [3:0] new_code_s;
  logic       rx_read_s;
  logic       tx_active_s;
  logic       tx_write_s;
  logic [7:0] tx_byte_s;

  // Frame decode from the two captured bytes.
  always_comb begin
    digit_off_s = b0_r - ASCII_ZERO;
    digit_cmd_s = (b0_r >= ASCII_ZERO) && (digit_off_s < 8'(NUM_DIGITS));
    b1_num_s    = (b1_r >= ASCII_ZERO) && (b1_r <= ASCII_NINE);
    b1_space_s  = (b1_r == ASCII_SPACE);
    clear_cmd_s = (b0_r == CMD_CLEAR_B0) && (b1_r == CMD_CLEAR_B1);
    read_cmd_s  = (b0_r == CMD_READ_B0) && (b1_r == CMD_READ_B1);
    valid_s     = (digit_cmd_s && (b1_num_s || b1_space_s)) || clear_cmd_s || read_cmd_s;
    if (b1_num_s) begin
      new_code_s = b1_r[3:0];
    end else begin
      new_code_s = BLANK_CODE;
    end
  end

  // RX pop and TX push strobes. Both depend on the FIFO flag of the same
  // cycle, so they are decoded from registered state rather than registered
  // themselves; this keeps a pop off an empty FIFO and a push into a full one
  // impossible.
  always_comb begin
    rx_read_s   = ((state_r == ST_IDLE) || (state_r == ST_WAIT_B1)) && !uart_rx_fifo_empty;
    tx_active_s = (state_r == ST_READBACK) || (state_r == ST_REPLY);
    tx_write_s  = tx_active_s && !uart_tx_fifo_full;
    case (state_r)
      ST_READBACK: tx_byte_s = code_to_ascii(snap_r[4*NUM_DIGITS-1 -: 4]);
      ST_REPLY: begin
        if (reply_ok_r) begin
          tx_byte_s = (cnt_r == '0) ? OK_B0 : OK_B1;
        end else begin
          tx_byte_s = (cnt_r == '0) ? ER_B0 : ER_B1;
        end
      end
      default: tx_byte_s = 8'h00;
    endcase
  end

  // Command FSM, display registers and reply sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      b0_r          <= 8'h00;
      b1_r          <= 8'h00;
      disp_r        <= {NUM_DIGITS{BLANK_CODE}};
      snap_r        <= {NUM_DIGITS{BLANK_CODE}};
      cnt_r         <= '0;
      tmo_cnt_r     <= '0;
      reply_ok_r    <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      frame_error_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_read_s) begin
            state_r <= ST_CAP_B0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CAP_B0: begin
          b0_r      <= uart_rx_fifo_data;
          tmo_cnt_r <= '0;
          state_r   <= ST_WAIT_B1;
        end
        ST_WAIT_B1: begin
          // A pop in the expiring cycle still wins over the timeout.
          if (rx_read_s) begin
            state_r <= ST_CAP_B1;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r       <= ST_REPLY;
            reply_ok_r    <= 1'b0;
            cnt_r         <= '0;
            frame_error_r <= 1'b1;
            tmo_cnt_r     <= '0;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 1'b1;
          end
        end
        ST_CAP_B1: begin
          b1_r    <= uart_rx_fifo_data;
          state_r <= ST_CHECK;
        end
        ST_CHECK: begin
          if (valid_s) begin
            state_r <= ST_EXEC;
          end else begin
            state_r       <= ST_REPLY;
            reply_ok_r    <= 1'b0;
            cnt_r         <= '0;
            frame_error_r <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (read_cmd_s) begin
            snap_r  <= disp_r;
            cnt_r   <= '0;
            state_r <= ST_READBACK;
          end else begin
            if (clear_cmd_s) begin
              disp_r <= {NUM_DIGITS{BLANK_CODE}};
            end else begin
              disp_r[{digit_off_s[3:0], 2'b00} +: 4] <= new_code_s;
            end
            reply_ok_r <= 1'b1;
            cnt_r      <= '0;
            state_r    <= ST_REPLY;
          end
        end
        ST_READBACK: begin
          // The snapshot shifts up one digit per sent byte so the top nibble
          // is always the next character, highest digit first.
          if (tx_write_s) begin
            if (cnt_r == CNT_RB_LAST) begin
              state_r    <= ST_REPLY;
              reply_ok_r <= 1'b1;
              cnt_r      <= '0;
            end else begin
              cnt_r  <= cnt_r + 1'b1;
              snap_r <= snap_r << 4;
            end
          end
        end
        ST_REPLY: begin
          if (tx_write_s) begin
            if (cnt_r == CNT_ONE) begin
              state_r <= ST_IDLE;
              cnt_r   <= '0;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  seg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_seg_scan (
    .clock     (clock),
    .reset     (reset),
    .numbers   (disp_r),
    .dig       (dig),
    .dig_value (dig_value)
  );

  assign uart_rx_fifo_read  = rx_read_s;
  assign uart_tx_fifo_write = tx_write_s;
  assign uart_tx_fifo_data  = tx_byte_s;
  assign display_numbers    = disp_r;
  assign frame_error        = frame_error_r;

endmodule

// File: tb/tb_display_cmd_ctrl.sv
// Randomised self-checking bench for display_cmd_ctrl with a frame-level
// reference model (digit array + expected reply byte queue).
module tb_display_cmd_ctrl;

  localparam int N   = 8;
  localparam int SD  = 8;
  localparam int TMO = 64;

  logic         clock = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_read;
  logic         rx_empty;
  logic [7:0]   tx_data;
  logic         tx_write;
  logic         tx_full;
  logic [N-1:0] dig;
  logic [3:0]   dig_value;
  logic [4*N-1:0] disp;
  logic         frame_error;

  always #5 clock = ~clock;

  display_cmd_ctrl #(.NUM_DIGITS(N), .SCAN_DIV(SD), .TIMEOUT_CYCLES(TMO)) dut (
    .clock              (clock),
    .reset              (reset),
    .uart_rx_fifo_data  (rx_data),
    .uart_rx_fifo_read  (rx_read),
    .uart_rx_fifo_empty (rx_empty),
    .uart_tx_fifo_data  (tx_data),
    .uart_tx_fifo_write (tx_write),
    .uart_tx_fifo_full  (tx_full),
    .dig                (dig),
    .dig_value          (dig_value),
    .display_numbers    (disp),
    .frame_error        (frame_error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  byte unsigned rx_q[$];
  byte unsigned tx_got[$];
  byte unsigned tx_exp[$];
  int  model[N];
  int  fe_count = 0;
  int  fe_exp = 0;
  bit  full_req = 1'b0;
  bit  rand_full = 1'b0;
  int  cyc_no = 0;
  int  first_tx_cyc = -1;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4*N-1:0] model_packed();
    logic [4*N-1:0] p;
    for (int i = 0; i < N; i++) p[4*i +: 4] = model[i][3:0];
    return p;
  endfunction

  // Frame-level reference: what the display becomes and what gets replied.
  function automatic void model_apply(input byte unsigned b0, input byte unsigned b1);
    bit ok;
    ok = 1'b1;
    if (b0 >= 8'h30 && int'(b0) < 8'h30 + N && ((b1 >= 8'h30 && b1 <= 8'h39) || b1 == 8'h20)) begin
      model[b0 - 8'h30] = (b1 == 8'h20) ? 15 : int'(b1) - 8'h30;
    end else if (b0 == 8'h43 && b1 == 8'h21) begin
      for (int i = 0; i < N; i++) model[i] = 15;
    end else if (b0 == 8'h52 && b1 == 8'h3F) begin
      for (int i = N - 1; i >= 0; i--) tx_exp.push_back((model[i] == 15) ? 8'h20 : 8'(8'h30 + model[i]));
    end else begin
      ok = 1'b0;
    end
    if (ok) begin
      tx_exp.push_back(8'h4F);
      tx_exp.push_back(8'h6B);
    end else begin
      tx_exp.push_back(8'h45);
      tx_exp.push_back(8'h72);
      fe_exp++;
    end
  endfunction

  // One clock: drive inputs at the falling edge, then act as RX/TX FIFOs.
  task automatic cyc();
    @(negedge clock);
    if (rand_full) full_req = ($urandom_range(0, 3) == 0);
    rx_empty = (rx_q.size() == 0);
    tx_full  = full_req;
    #1;
    cyc_no++;
    if (rx_read) begin
      check_val("rx_read_nonempty", rx_empty, 1'b0);
      if (rx_q.size() > 0) rx_data = rx_q.pop_front();
    end
    if (tx_full) check_val("no_write_when_full", tx_write, 1'b0);
    if (tx_write && !tx_full) begin
      if (tx_got.size() == 0) first_tx_cyc = cyc_no;
      tx_got.push_back(tx_data);
    end
    if (frame_error) fe_count++;
  endtask

  task automatic wait_reply(input string tag);
    int budget;
    budget = 3000;
    while (tx_got.size() < tx_exp.size() && budget > 0) begin
      cyc();
      budget--;
    end
    check_val({tag, "_in_time"}, budget > 0, 1'b1);
    repeat (8) cyc();
    check_val({tag, "_len"}, tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_got.size() && i < tx_exp.size(); i++)
      check_val({tag, "_byte"}, tx_got[i], tx_exp[i]);
    check_val({tag, "_disp"}, disp, model_packed());
    check_val({tag, "_ferr_cnt"}, fe_count, fe_exp);
    tx_got.delete();
    tx_exp.delete();
  endtask

  task automatic do_frame(input string tag, input byte unsigned b0, input byte unsigned b1, input int gap);
    model_apply(b0, b1);
    rx_q.push_back(b0);
    repeat (gap) cyc();
    rx_q.push_back(b1);
    wait_reply(tag);
  endtask

  task automatic scan_check();
    logic [N-1:0] prev;
    int last_change;
    int idx;
    int changes;
    prev = dig;
    last_change = -1;
    changes = 0;
    for (int c = 0; c < 10 * SD; c++) begin
      cyc();
      check_val("dig_onehot", $countones(dig), 1);
      if (dig != prev) begin
        check_val("dig_rotate", dig, {prev[N-2:0], prev[N-1]});
        if (last_change >= 0) check_val("scan_period", cyc_no - last_change, SD);
        last_change = cyc_no;
        prev = dig;
        changes++;
      end
      idx = 0;
      for (int i = 0; i < N; i++) if (dig[i]) idx = i;
      check_val("dig_value", dig_value, model[idx][3:0]);
    end
    check_val("scan_changes", changes >= N, 1'b1);
  endtask

  initial begin
    byte unsigned b0;
    byte unsigned b1;
    int kind;
    int t0;
    int budget;
    reset   = 1'b1;
    rx_data = 8'h00;
    rx_empty = 1'b1;
    tx_full = 1'b0;
    for (int i = 0; i < N; i++) model[i] = 15;
    repeat (3) cyc();
    check_val("rst_disp", disp, {N{4'hF}});
    check_val("rst_dig", dig, 8'h01);
    check_val("rst_dig_value", dig_value, 4'hF);
    check_val("rst_tx_write", tx_write, 1'b0);
    check_val("rst_tx_data", tx_data, 8'h00);
    check_val("rst_rx_read", rx_read, 1'b0);
    check_val("rst_frame_error", frame_error, 1'b0);
    reset = 1'b0;

    // Basic digit write, invalid frames, read-back.
    do_frame("set_d3", 8'h33, 8'h37, 0);
    check_val("set_d3_const", disp, 32'hFFFF_7FFF);
    do_frame("bad_index", 8'h39, 8'h31, 2);
    do_frame("bad_value", 8'h32, 8'h41, 1);
    do_frame("readback", 8'h52, 8'h3F, 3);

    // Inter-byte timeout, then recovery.
    model_apply(8'h31, 8'h00);
    tx_exp.delete();
    tx_exp.push_back(8'h45);
    tx_exp.push_back(8'h72);
    t0 = cyc_no;
    first_tx_cyc = -1;
    rx_q.push_back(8'h31);
    wait_reply("timeout");
    check_val("timeout_not_early", (first_tx_cyc - t0) >= TMO, 1'b1);
    check_val("timeout_not_late", (first_tx_cyc - t0) <= TMO + 8, 1'b1);
    do_frame("after_tmo", 8'h31, 8'h35, 0);

    // Long TX stall during a reply.
    full_req = 1'b1;
    model_apply(8'h36, 8'h34);
    rx_q.push_back(8'h36);
    rx_q.push_back(8'h34);
    repeat (20) cyc();
    check_val("stall_no_bytes", tx_got.size(), 0);
    full_req = 1'b0;
    wait_reply("stall");

    // Scan sequence with some digits lit.
    scan_check();

    // Randomised frames with random TX backpressure.
    rand_full = 1'b1;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0, 1: begin
          b0 = 8'(8'h30 + $urandom_range(0, N - 1));
          b1 = ($urandom_range(0, 4) == 0) ? 8'h20 : 8'(8'h30 + $urandom_range(0, 9));
        end
        2: begin
          b0 = 8'(8'h30 + $urandom_range(N, 9));
          b1 = 8'(8'h30 + $urandom_range(0, 9));
        end
        3: begin b0 = 8'h43; b1 = 8'h21; end
        4: begin b0 = 8'h52; b1 = 8'h3F; end
        default: begin
          b0 = 8'($urandom_range(0, 255));
          b1 = 8'($urandom_range(0, 255));
        end
      endcase
      do_frame("rand", b0, b1, $urandom_range(0, 12));
    end
    rand_full = 1'b0;
    full_req = 1'b0;

    // Reset in the middle of a read-back reply.
    do_frame("pre_rst_set", 8'h37, 8'h32, 0);
    model_apply(8'h52, 8'h3F);
    rx_q.push_back(8'h52);
    rx_q.push_back(8'h3F);
    budget = 200;
    while (tx_got.size() < 3 && budget > 0) begin
      cyc();
      budget--;
    end
    check_val("rst_mid_reply_started", budget > 0, 1'b1);
    reset = 1'b1;
    cyc();
    check_val("rst_mid_tx_write", tx_write, 1'b0);
    check_val("rst_mid_disp", disp, {N{4'hF}});
    check_val("rst_mid_dig", dig, 8'h01);
    check_val("rst_mid_dig_value", dig_value, 4'hF);
    check_val("rst_mid_tx_data", tx_data, 8'h00);
    check_val("rst_mid_frame_error", frame_error, 1'b0);
    cyc();
    check_val("rst_mid_tx_write2", tx_write, 1'b0);
    reset = 1'b0;
    rx_q.delete();
    tx_got.delete();
    tx_exp.delete();
    for (int i = 0; i < N; i++) model[i] = 15;
    fe_count = 0;
    fe_exp = 0;
    do_frame("post_rst", 8'h30, 8'h39, 1);
    do_frame("clear", 8'h43, 8'h21, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
